// File: rtl/sha_miner_pkg.sv
// Shared types and widths for the SHA-256 nonce driver and its found-result FIFO.
package sha_miner_pkg;

    localparam int NONCE_W  = 32;
    localparam int BLOCK_W  = 256;
    localparam int DIGEST_W = 256;
    localparam int FOUND_W  = NONCE_W + DIGEST_W;
    // One extra bit so a count of 2^32 nonces fits.
    localparam int CNT_W    = NONCE_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } drv_state_e;

    // A requested count of zero stands for the full 2^32 nonce space.
    function automatic logic [CNT_W-1:0] count_span(input logic [NONCE_W-1:0] cnt);
        logic [CNT_W-1:0] span;
        if (cnt == {NONCE_W{1'b0}}) begin
            span = {1'b1, {NONCE_W{1'b0}}};
        end else begin
            span = {1'b0, cnt};
        end
        return span;
    endfunction

    // Overwrite the low nonce field of a block template.
    function automatic logic [BLOCK_W-1:0] insert_nonce(input logic [BLOCK_W-1:0] blk,
                                                        input logic [NONCE_W-1:0] nonce);
        logic [BLOCK_W-1:0] r;
        r              = blk;
        r[NONCE_W-1:0] = nonce;
        return r;
    endfunction

endpackage

// File: rtl/sha_found_fifo.sv
// Synchronous FIFO holding (nonce, digest) hits; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module sha_found_fifo
    import sha_miner_pkg::*;
#(
    parameter int WIDTH = FOUND_W,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push_s, do_pop_s;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance for accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push_s};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop_s};
    end

    // Pointer registers, emptied only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/sha256_nonce_driver.sv
// Work-item driver for sha256_3_pipeline: issues one block per cycle with an
// incrementing nonce, tracks in-order returns and queues digests whose low
// ZERO_BITS bits are zero.
// Optional: define SHA_DRIVER_STATS_EN to add the saturating hash_count port.
module sha256_nonce_driver
    import sha_miner_pkg::*;
#(
    parameter int PIPE_LATENCY = 66,
    parameter int ZERO_BITS    = 32,
    parameter int FOUND_DEPTH  = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                work_valid,
    output logic                work_ready,
    input  logic [BLOCK_W-1:0]  work_block,
    input  logic [NONCE_W-1:0]  work_nonce_start,
    input  logic [NONCE_W-1:0]  work_nonce_count,
    input  logic                abort,
    output logic                pipe_write_en,
    output logic [BLOCK_W-1:0]  pipe_block,
    input  logic [DIGEST_W-1:0] pipe_digest,
    input  logic                pipe_valid,
    output logic                found_valid,
    input  logic                found_ready,
    output logic [NONCE_W-1:0]  found_nonce,
    output logic [DIGEST_W-1:0] found_digest,
    output logic                busy,
    output logic                overflow
`ifdef SHA_DRIVER_STATS_EN
    ,
    output logic [47:0]         hash_count
`endif
);

    // Returns are matched purely by order, so latency only needs to be sane.
    if (PIPE_LATENCY < 1 || ZERO_BITS < 1 || ZERO_BITS > 255 || FOUND_DEPTH < 2) begin : g_bad_param
        $error("sha256_nonce_driver: parameter out of range");
    end

    drv_state_e          state_q, state_d;
    logic [NONCE_W-1:0]  start_q, start_d;
    logic [CNT_W-1:0]    span_q, span_d;
    logic [CNT_W-1:0]    issue_q, issue_d;
    logic [CNT_W-1:0]    ret_q, ret_d;
    logic                pipe_write_en_q, pipe_write_en_d;
    logic [BLOCK_W-1:0]  pipe_block_q, pipe_block_d;
    logic                overflow_q, overflow_d;

    logic                ret_take_s, hit_s, pop_s;
    logic                fifo_full_s, fifo_empty_s;
    logic [FOUND_W-1:0]  fifo_in_s, fifo_head_s;

    // A return is only ours while something is still outstanding.
    assign ret_take_s = pipe_valid && (ret_q < issue_q);
    assign hit_s      = ret_take_s && (pipe_digest[ZERO_BITS-1:0] == '0);
    assign pop_s      = found_ready && !fifo_empty_s;
    assign fifo_in_s  = {start_q + ret_q[NONCE_W-1:0], pipe_digest};

    // Next-state logic for the issue/drain FSM and its counters.
    always_comb begin
        state_d         = state_q;
        start_d         = start_q;
        span_d          = span_q;
        issue_d         = issue_q;
        pipe_write_en_d = 1'b0;
        pipe_block_d    = pipe_block_q;
        if (ret_take_s) begin
            ret_d = ret_q + CNT_W'(1);
        end else begin
            ret_d = ret_q;
        end
        if (hit_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
        case (state_q)
            IDLE: begin
                if (work_valid) begin
                    // The first block goes out on the accept edge itself.
                    state_d         = ISSUE;
                    start_d         = work_nonce_start;
                    span_d          = count_span(work_nonce_count);
                    issue_d         = CNT_W'(1);
                    ret_d           = {CNT_W{1'b0}};
                    pipe_write_en_d = 1'b1;
                    pipe_block_d    = insert_nonce(work_block, work_nonce_start);
                    overflow_d      = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (abort || (issue_q == span_q)) begin
                    state_d = DRAIN;
                end else begin
                    pipe_write_en_d = 1'b1;
                    pipe_block_d    = insert_nonce(pipe_block_q, start_q + issue_q[NONCE_W-1:0]);
                    issue_d         = issue_q + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (ret_d == issue_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q         <= IDLE;
            start_q         <= {NONCE_W{1'b0}};
            span_q          <= {CNT_W{1'b0}};
            issue_q         <= {CNT_W{1'b0}};
            ret_q           <= {CNT_W{1'b0}};
            pipe_write_en_q <= 1'b0;
            pipe_block_q    <= {BLOCK_W{1'b0}};
            overflow_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            start_q         <= start_d;
            span_q          <= span_d;
            issue_q         <= issue_d;
            ret_q           <= ret_d;
            pipe_write_en_q <= pipe_write_en_d;
            pipe_block_q    <= pipe_block_d;
            overflow_q      <= overflow_d;
        end
    end

    sha_found_fifo #(
        .WIDTH (FOUND_W),
        .DEPTH (FOUND_DEPTH)
    ) u_found_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .push_i  (hit_s),
        .data_i  (fifo_in_s),
        .pop_i   (found_ready),
        .data_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign work_ready    = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign pipe_write_en = pipe_write_en_q;
    assign pipe_block    = pipe_block_q;
    assign overflow      = overflow_q;
    assign found_valid   = !fifo_empty_s;
    assign found_nonce   = fifo_head_s[FOUND_W-1:DIGEST_W];
    assign found_digest  = fifo_head_s[DIGEST_W-1:0];

`ifdef SHA_DRIVER_STATS_EN
    logic [47:0] hash_count_q, hash_count_d;

    // Count accepted returns, holding at all-ones.
    always_comb begin
        if (ret_take_s && (hash_count_q != 48'hFFFF_FFFF_FFFF)) begin
            hash_count_d = hash_count_q + 48'd1;
        end else begin
            hash_count_d = hash_count_q;
        end
    end

    // Statistics register, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            hash_count_q <= 48'd0;
        end else begin
            hash_count_q <= hash_count_d;
        end
    end

    assign hash_count = hash_count_q;
`endif

endmodule
